// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the register file / scoreboard slice: WB bus layout and sizing.
package regfile_sb_pkg;

   localparam int unsigned WB_TO_REGFILE_BUS_WD = 41;
   localparam int unsigned NREG                 = 32;
   localparam int unsigned SB_CNT_W             = 2;
   localparam int unsigned REG_AW               = 5;

   typedef struct packed {
      logic [3:0]  wen;
      logic [4:0]  dest;
      logic [31:0] wdata;
   } wb_bus_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-writer counter with synchronous clear and an overflow pulse.
module sb_counter
   import regfile_sb_pkg::*;
#(
   parameter int unsigned CNT_W = SB_CNT_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Simultaneous inc/dec cancel; dec at zero is a retire of a writer flushed earlier.
   always_comb begin
      cnt_d    = cnt_q;
      overflow = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !dec) begin
         if (cnt_q == CntMax) begin
            overflow = 1'b1;
         end else begin
            cnt_d = cnt_q + CntOne;
         end
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - CntOne;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with byte-merge write-first bypass and a per-register
// pending-writer scoreboard that flags read operands still owned by an in-flight writer.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int unsigned NREG  = regfile_sb_pkg::NREG,
   parameter int unsigned CNT_W = SB_CNT_W
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [WB_TO_REGFILE_BUS_WD-1:0] wb_to_regfile_bus,
   input  logic                            id_issue_valid,
   input  logic                            id_issue_gr_we,
   input  logic [REG_AW-1:0]               id_issue_dest,
   input  logic                            flush,
   input  logic [REG_AW-1:0]               raddr1,
   input  logic [REG_AW-1:0]               raddr2,
   output logic [31:0]                     rdata1,
   output logic [31:0]                     rdata2,
   output logic                            rs1_busy,
   output logic                            rs2_busy,
   output logic                            sb_overflow
);

   wb_bus_t wb;
   logic    retire;
   logic    inc;
   logic    dec;

   logic [31:0]      rf_q [NREG];
   logic [CNT_W-1:0] cnt  [NREG];
   logic [NREG-1:0]  ovf;
   logic             sb_overflow_q;

   assign wb     = wb_bus_t'(wb_to_regfile_bus);
   // Bus content is meaningless while reset is held, so it must not reach the bypass.
   assign retire = (wb.wen != 4'b0000) && resetn;
   assign dec    = retire && (wb.dest != '0);
   assign inc    = id_issue_valid && id_issue_gr_we && (id_issue_dest != '0);

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (lanes[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
      end else if (dec) begin
         for (int b = 0; b < 4; b++) begin
            if (wb.wen[b]) rf_q[wb.dest][8*b +: 8] <= wb.wdata[8*b +: 8];
         end
      end
   end

   assign cnt[0] = '0;
   assign ovf[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_cnt
      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk      (clk),
         .resetn   (resetn),
         .clr      (flush),
         .inc      (inc && (id_issue_dest == REG_AW'(r))),
         .dec      (dec && (wb.dest == REG_AW'(r))),
         .cnt      (cnt[r]),
         .overflow (ovf[r])
      );
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sb_overflow_q <= 1'b0;
      end else if (|ovf) begin
         sb_overflow_q <= 1'b1;
      end
   end

   assign sb_overflow = sb_overflow_q;

   logic hit1, hit2;

   assign hit1 = retire && (wb.dest == raddr1);
   assign hit2 = retire && (wb.dest == raddr2);

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != '0) rdata1 = hit1 ? merge_bytes(rf_q[raddr1], wb.wdata, wb.wen) : rf_q[raddr1];
      if (raddr2 != '0) rdata2 = hit2 ? merge_bytes(rf_q[raddr2], wb.wdata, wb.wen) : rf_q[raddr2];
   end

   // A writer retiring this cycle is served by the bypass, so it is discounted from busy.
   assign rs1_busy = (raddr1 != '0) && (cnt[raddr1] > {{(CNT_W-1){1'b0}}, hit1});
   assign rs2_busy = (raddr2 != '0) && (cnt[raddr2] > {{(CNT_W-1){1'b0}}, hit2});

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against a behavioural register/scoreboard model.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        resetn;
   logic [40:0] bus;
   logic        iv, iwe, flush;
   logic [4:0]  idest, ra1, ra2;
   logic [31:0] rdata1, rdata2;
   logic        rs1_busy, rs2_busy, sb_overflow;

   int checks = 0;
   int errors = 0;

   logic [31:0] rf_m [32];
   int          cnt_m [32];
   logic        ovf_m;

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk               (clk),
      .resetn            (resetn),
      .wb_to_regfile_bus (bus),
      .id_issue_valid    (iv),
      .id_issue_gr_we    (iwe),
      .id_issue_dest     (idest),
      .flush             (flush),
      .raddr1            (ra1),
      .raddr2            (ra2),
      .rdata1            (rdata1),
      .rdata2            (rdata2),
      .rs1_busy          (rs1_busy),
      .rs2_busy          (rs2_busy),
      .sb_overflow       (sb_overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (a == 0) return 32'h0;
      v = rf_m[a];
      if (bus[40:37] != 0 && bus[36:32] == a)
         for (int i = 0; i < 4; i++) if (bus[37+i]) v[8*i +: 8] = bus[8*i +: 8];
      return v;
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      int c;
      if (a == 0) return 1'b0;
      c = cnt_m[a];
      if (bus[40:37] != 0 && bus[36:32] == a) c = c - 1;
      return c > 0;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         rf_m[r]  = 32'h0;
         cnt_m[r] = 0;
      end
      ovf_m = 1'b0;
   endtask

   task automatic model_update();
      logic [3:0]  wen;
      logic [4:0]  dest;
      logic        inc, dec;
      if (!resetn) return;
      wen  = bus[40:37];
      dest = bus[36:32];
      if (dest != 0)
         for (int i = 0; i < 4; i++) if (wen[i]) rf_m[dest][8*i +: 8] = bus[8*i +: 8];
      inc = iv && iwe && idest != 0;
      dec = wen != 0 && dest != 0;
      if (flush) begin
         for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      end else if (!(inc && dec && idest == dest)) begin
         if (inc) begin
            if (cnt_m[idest] == 3) ovf_m = 1'b1;
            else cnt_m[idest]++;
         end
         if (dec && cnt_m[dest] > 0) cnt_m[dest]--;
      end
   endtask

   task automatic compare();
      check("rdata1", rdata1, exp_rd(ra1));
      check("rdata2", rdata2, exp_rd(ra2));
      check("rs1_busy", 32'(rs1_busy), 32'(exp_busy(ra1)));
      check("rs2_busy", 32'(rs2_busy), 32'(exp_busy(ra2)));
      check("sb_overflow", 32'(sb_overflow), 32'(ovf_m));
   endtask

   task automatic cycle();
      @(negedge clk);
      compare();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input logic [3:0] wen, input logic [4:0] dest, input logic [31:0] wd,
                        input logic issue, input logic [4:0] idst, input logic fl,
                        input logic [4:0] a1, input logic [4:0] a2);
      bus   = {wen, dest, wd};
      iv    = issue;
      iwe   = issue;
      idest = idst;
      flush = fl;
      ra1   = a1;
      ra2   = a2;
   endtask

   initial begin
      model_reset();
      resetn = 1'b0;
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
      cycle();
      check("reset_r5", rdata1, 32'h0);
      check("reset_busy5", 32'(rs1_busy), 32'h0);
      tick();
      resetn = 1'b1;

      // Full write, bypass then array read
      drive(4'hF, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
      cycle(); check("bypass_full", rdata1, 32'hDEADBEEF); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
      cycle(); check("rf_full", rdata1, 32'hDEADBEEF); tick();

      // Partial byte write
      drive(4'b0101, 5'd3, 32'h11223344, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
      cycle(); check("bypass_bytes", rdata1, 32'hDE22BE44); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0);
      cycle(); check("rf_bytes", rdata1, 32'hDE22BE44); tick();
      drive(4'hF, 5'd0, 32'd1234, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
      cycle(); check("r0_bypass", rdata1, 32'h0); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
      cycle(); check("r0_rf", rdata1, 32'h0); tick();

      // Three issues to r7, then three retires
      drive(4'h0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
      cycle(); check("r7_issue0", 32'(rs1_busy), 32'h0); tick();
      for (int k = 1; k < 3; k++) begin
         cycle(); check("r7_issue", 32'(rs1_busy), 32'h1); tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(4'hF, 5'd7, 32'h700 + k, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
         cycle(); check("r7_retire", 32'(rs1_busy), (k < 2) ? 32'h1 : 32'h0); tick();
      end
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
      cycle(); check("r7_idle", 32'(rs1_busy), 32'h0); check("r7_val", rdata1, 32'h702); tick();

      // Concurrent issue/retire on r9, then overflow
      drive(4'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
      cycle(); tick();
      drive(4'hF, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
      cycle(); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
      cycle(); check("r9_still_busy", 32'(rs1_busy), 32'h1); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
      for (int k = 0; k < 3; k++) begin cycle(); tick(); end
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
      cycle(); check("overflow_set", 32'(sb_overflow), 32'h1); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 5'd0);
      cycle(); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
      cycle(); check("overflow_sticky", 32'(sb_overflow), 32'h1);
      check("r9_flushed", 32'(rs1_busy), 32'h0); tick();

      // Flush with concurrent retire
      drive(4'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd5);
      cycle(); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd4, 5'd5);
      cycle(); tick();
      drive(4'hF, 5'd4, 32'hA5, 1'b0, 5'd0, 1'b1, 5'd4, 5'd5);
      cycle(); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd5);
      cycle(); check("flush_b4", 32'(rs1_busy), 32'h0); check("flush_b5", 32'(rs2_busy), 32'h0);
      check("flush_rf4", rdata1, 32'hA5); tick();
      drive(4'hF, 5'd5, 32'h55, 1'b0, 5'd0, 1'b0, 5'd4, 5'd5);
      cycle(); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd4, 5'd5);
      cycle(); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd5);
      cycle(); check("cnt5_one", 32'(cnt_m[5]), 32'h1); check("b5_after", 32'(rs2_busy), 32'h1); tick();
      drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd4, 5'd5);
      cycle(); tick();

      // Randomised traffic, with an asynchronous reset in the middle
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
               5'($urandom_range(0, 9)), $urandom,
               1'($urandom), 5'($urandom_range(0, 9)),
               ($urandom_range(0, 40) == 0),
               ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9)),
               5'($urandom_range(0, 9)));
         iwe = 1'($urandom_range(0, 3) != 0);
         if (n == 1500) begin
            drive(4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd7);
            #1 resetn = 1'b0;
            #1;
            check("async_rd1", rdata1, 32'h0);
            check("async_rd2", rdata2, 32'h0);
            check("async_busy", 32'({rs1_busy, rs2_busy}), 32'h0);
            check("async_ovf", 32'(sb_overflow), 32'h0);
            model_reset();
         end
         cycle();
         tick();
         if (!resetn) begin
            #2 resetn = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
